nios_setup_nios2f_cpu_ocimem_arbiter: RTL and testbench

- Sysclk-domain controller that shares the single-port on-chip debug memory (OCI RAM) between two requesters: the CPU's Avalon debug-memory slave and the JTAG debug command path.
- The JTAG path is driven by the `take_action_ocimem_*` pulses and the `jdo` word from the debug slave sysclk block.
- The block decodes JTAG commands, holds one pending JTAG request, and arbitrates round-robin against the CPU.
- It sequences the 1-cycle-latency RAM and returns JTAG read data in MonDReg.

---
 rtl/nios_setup_nios2f_cpu_ocimem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_nios_setup_nios2f_cpu_ocimem_arbiter.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_setup_nios2f_cpu_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the CPU Avalon slave and the JTAG command path.
// Optional build macro OCIMEM_CPU_WR_PROTECT_EN blocks CPU writes to the upper (monitor) half.
module nios_setup_nios2f_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
`ifdef OCIMEM_CPU_WR_PROTECT_EN
    ,
    output logic              cpu_wr_violation
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU_RD,
        ST_JTAG_RD
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [ADDR_W-1:0] jtag_addr;
    logic              pend;
    logic              pend_wr;
    logic [31:0]       pend_wdata;
    logic              last_grant_jtag;
    logic [31:0]       readdata_q;

    logic              cpu_req;
    logic              jtag_post;
    logic              grant_cpu;
    logic              grant_jtag;
    logic              wr_blocked;
    logic              violation_c;

    assign cpu_req   = avs_read | avs_write;
    assign jtag_post = (take_action_ocimem_a & jdo[35]) | take_no_action_ocimem_a | take_action_ocimem_b;

`ifdef OCIMEM_CPU_WR_PROTECT_EN
    assign wr_blocked       = avs_address[ADDR_W-1];
    assign cpu_wr_violation = violation_c;
    logic unused_bits;
    assign unused_bits = &{1'b0, jdo[37], jdo[2:0]};
`else
    assign wr_blocked = 1'b0;
    logic unused_bits;
    assign unused_bits = &{1'b0, jdo[37], jdo[2:0], violation_c};
`endif

    // Round-robin between the two requesters; only IDLE can start an access, and reset gates everything.
    always_comb begin
        grant_cpu  = 1'b0;
        grant_jtag = 1'b0;
        if (reset_n && state == ST_IDLE) begin
            if (cpu_req && pend) begin
                if (last_grant_jtag) begin
                    grant_cpu = 1'b1;
                end else begin
                    grant_jtag = 1'b1;
                end
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (pend) begin
                grant_jtag = 1'b1;
            end
        end
    end

    always_comb begin
        next_state      = state;
        ram_address     = '0;
        ram_wren        = 1'b0;
        ram_byteenable  = 4'h0;
        ram_wdata       = 32'h0;
        avs_waitrequest = cpu_req & reset_n;
        violation_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_cpu) begin
                    ram_address = avs_address;
                    if (avs_write) begin
                        avs_waitrequest = 1'b0;
                        if (wr_blocked) begin
                            violation_c = 1'b1;
                        end else begin
                            ram_wren       = 1'b1;
                            ram_byteenable = avs_byteenable;
                            ram_wdata      = avs_writedata;
                        end
                    end else begin
                        next_state = ST_CPU_RD;
                    end
                end else if (grant_jtag) begin
                    ram_address = jtag_addr;
                    if (pend_wr) begin
                        ram_wren       = 1'b1;
                        ram_byteenable = 4'hF;
                        ram_wdata      = pend_wdata;
                    end else begin
                        next_state = ST_JTAG_RD;
                    end
                end
            end
            ST_CPU_RD: begin
                avs_waitrequest = 1'b0;
                next_state      = ST_IDLE;
            end
            ST_JTAG_RD: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign avs_readdata = (state == ST_CPU_RD) ? ram_rdata : readdata_q;
    assign jtag_busy    = pend | (state == ST_JTAG_RD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Later assignments win: an ocimem_a address load overrides a post-access increment,
    // and a new overrun overrides a same-cycle clear request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_addr       <= '0;
            pend            <= 1'b0;
            pend_wr         <= 1'b0;
            pend_wdata      <= 32'h0;
            last_grant_jtag <= 1'b0;
            readdata_q      <= 32'h0;
            MonDReg         <= 32'h0;
            jtag_overrun    <= 1'b0;
        end else begin
            if (grant_cpu) begin
                last_grant_jtag <= 1'b0;
            end else if (grant_jtag) begin
                last_grant_jtag <= 1'b1;
            end

            if (state == ST_CPU_RD) begin
                readdata_q <= ram_rdata;
            end

            if (state == ST_JTAG_RD) begin
                MonDReg   <= ram_rdata;
                pend      <= 1'b0;
                jtag_addr <= jtag_addr + 1'b1;
            end

            if (grant_jtag && pend_wr) begin
                pend      <= 1'b0;
                jtag_addr <= jtag_addr + 1'b1;
            end

            if (take_action_ocimem_a && jdo[36]) begin
                jtag_overrun <= 1'b0;
            end

            if (jtag_post) begin
                if (pend) begin
                    jtag_overrun <= 1'b1;
                end else begin
                    pend       <= 1'b1;
                    pend_wr    <= take_action_ocimem_b;
                    pend_wdata <= jdo[34:3];
                end
            end

            if (take_action_ocimem_a) begin
                jtag_addr <= jdo[ADDR_W+16:17];
            end
        end
    end

endmodule

// File: tb/tb_nios_setup_nios2f_cpu_ocimem_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle, plus directed literal checks.
module tb_nios_setup_nios2f_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_address;
    logic        ram_wren;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;
`ifdef OCIMEM_CPU_WR_PROTECT_EN
    logic        cpu_wr_violation;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    nios_setup_nios2f_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_address             (ram_address),
        .ram_wren                (ram_wren),
        .ram_byteenable          (ram_byteenable),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
`ifdef OCIMEM_CPU_WR_PROTECT_EN
        ,
        .cpu_wr_violation        (cpu_wr_violation)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [7:0] a);
        return ({24'd0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // Synchronous RAM with one cycle of read latency, serving the DUT.
    logic [31:0] ram_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = init_word(8'(i));
        ram_rdata = 32'h0;
        forever begin
            @(posedge clk);
            ram_rdata <= ram_mem[ram_address];
            if (ram_wren) ram_mem[ram_address] <= merge_word(ram_mem[ram_address], ram_wdata, ram_byteenable);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, limit 1000000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: what each requester is owed, in terms of in-flight reads and a word array.
    logic [31:0] m_mem [256];
    logic [7:0]  m_addr;
    logic        m_pend;
    logic        m_pend_wr;
    logic [31:0] m_pend_data;
    logic        m_jrd;
    logic [7:0]  m_jrd_addr;
    logic        m_crd;
    logic [7:0]  m_crd_addr;
    logic        m_last_jtag;
    logic [31:0] m_mondreg;
    logic [31:0] m_rdhold;
    logic        m_overrun;
    logic        cpu_hold;

    task automatic model_reset();
        m_addr      = 8'h00;
        m_pend      = 1'b0;
        m_pend_wr   = 1'b0;
        m_pend_data = 32'h0;
        m_jrd       = 1'b0;
        m_jrd_addr  = 8'h00;
        m_crd       = 1'b0;
        m_crd_addr  = 8'h00;
        m_last_jtag = 1'b0;
        m_mondreg   = 32'h0;
        m_rdhold    = 32'h0;
        m_overrun   = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                                 input logic [3:0] be, input logic ta, input logic tna, input logic tb,
                                 input logic [37:0] jdo_v);
        avs_read                = rd;
        avs_write               = wr;
        avs_address             = addr;
        avs_writedata           = wd;
        avs_byteenable          = be;
        take_action_ocimem_a    = ta;
        take_no_action_ocimem_a = tna;
        take_action_ocimem_b    = tb;
        jdo                     = jdo_v;
    endtask

    // Per-cycle comparison against the model, then the model advances by one clock.
    task automatic checkCycle();
        logic        cpu_req, post, blocked, e_wait, e_wren, e_av, e_viol;
        logic [7:0]  e_addr, n_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_rdata;
        logic        n_pend, n_overrun;
        if (!reset_n) begin
            model_reset();
            cpu_hold = 1'b0;
            checkOutput("rst_wren", 32'(ram_wren), 32'h0);
            checkOutput("rst_wait", 32'(avs_waitrequest), 32'h0);
            checkOutput("rst_rdata", avs_readdata, 32'h0);
            checkOutput("rst_mondreg", MonDReg, 32'h0);
            checkOutput("rst_busy", 32'(jtag_busy), 32'h0);
            checkOutput("rst_overrun", 32'(jtag_overrun), 32'h0);
`ifdef OCIMEM_CPU_WR_PROTECT_EN
            checkOutput("rst_viol", 32'(cpu_wr_violation), 32'h0);
`endif
            return;
        end
        checkOutput("mondreg", MonDReg, m_mondreg);
        checkOutput("jtag_busy", 32'(jtag_busy), 32'(m_pend | m_jrd));
        checkOutput("jtag_overrun", 32'(jtag_overrun), 32'(m_overrun));

        cpu_req = avs_read | avs_write;
        e_wait  = cpu_req;
        e_wren  = 1'b0;
        e_av    = 1'b0;
        e_viol  = 1'b0;
        e_addr  = 8'h00;
        e_be    = 4'h0;
        e_wdata = 32'h0;
        e_rdata = m_rdhold;
        n_addr  = m_addr;
        n_pend  = m_pend;
`ifdef OCIMEM_CPU_WR_PROTECT_EN
        blocked = avs_address[7];
`else
        blocked = 1'b0;
`endif
        if (m_crd) begin
            e_rdata  = m_mem[m_crd_addr];
            e_wait   = 1'b0;
            m_rdhold = e_rdata;
            m_crd    = 1'b0;
        end else if (m_jrd) begin
            m_mondreg = m_mem[m_jrd_addr];
            m_jrd     = 1'b0;
            n_pend    = 1'b0;
            n_addr    = m_addr + 8'd1;
        end else if (cpu_req && (!m_pend || m_last_jtag)) begin
            m_last_jtag = 1'b0;
            e_av        = 1'b1;
            e_addr      = avs_address;
            if (avs_write) begin
                e_wait = 1'b0;
                if (blocked) begin
                    e_viol = 1'b1;
                end else begin
                    e_wren  = 1'b1;
                    e_be    = avs_byteenable;
                    e_wdata = avs_writedata;
                    m_mem[avs_address] = merge_word(m_mem[avs_address], avs_writedata, avs_byteenable);
                end
            end else begin
                m_crd      = 1'b1;
                m_crd_addr = avs_address;
            end
        end else if (m_pend) begin
            m_last_jtag = 1'b1;
            e_av        = 1'b1;
            e_addr      = m_addr;
            if (m_pend_wr) begin
                e_wren  = 1'b1;
                e_be    = 4'hF;
                e_wdata = m_pend_data;
                m_mem[m_addr] = m_pend_data;
                n_pend  = 1'b0;
                n_addr  = m_addr + 8'd1;
            end else begin
                m_jrd      = 1'b1;
                m_jrd_addr = m_addr;
            end
        end

        checkOutput("waitrequest", 32'(avs_waitrequest), 32'(e_wait));
        checkOutput("ram_wren", 32'(ram_wren), 32'(e_wren));
        checkOutput("avs_readdata", avs_readdata, e_rdata);
        if (e_av) checkOutput("ram_address", 32'(ram_address), 32'(e_addr));
        if (e_wren) begin
            checkOutput("ram_byteenable", 32'(ram_byteenable), 32'(e_be));
            checkOutput("ram_wdata", ram_wdata, e_wdata);
        end
`ifdef OCIMEM_CPU_WR_PROTECT_EN
        checkOutput("cpu_wr_violation", 32'(cpu_wr_violation), 32'(e_viol));
`endif

        post      = (take_action_ocimem_a & jdo[35]) | take_no_action_ocimem_a | take_action_ocimem_b;
        n_overrun = m_overrun;
        if (take_action_ocimem_a && jdo[36]) n_overrun = 1'b0;
        if (post) begin
            if (m_pend) begin
                n_overrun = 1'b1;
            end else begin
                n_pend      = 1'b1;
                m_pend_wr   = take_action_ocimem_b;
                m_pend_data = jdo[34:3];
            end
        end
        if (take_action_ocimem_a) n_addr = jdo[24:17];
        m_addr    = n_addr;
        m_pend    = n_pend;
        m_overrun = n_overrun;
        cpu_hold  = cpu_req & e_wait;
    endtask

    task automatic to_negedge();
        @(negedge clk);
        checkCycle();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        advance();
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd, input logic clr);
        logic [37:0] j;
        j        = 38'h0;
        j[24:17] = addr;
        j[35]    = rd;
        j[36]    = clr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j;
        j       = 38'h0;
        j[34:3] = data;
        return j;
    endfunction

    task automatic pulse_reset();
        reset_n = 1'b0;
        idle_tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic        h_rd, h_wr;
        logic [7:0]  h_addr;
        logic [31:0] h_wd;
        logic [3:0]  h_be;
        logic        r_ta, r_tna, r_tb;
        logic [37:0] r_jdo;
        logic [31:0] lo, hi;
        int          r;

        vectors     = 0;
        miscompares = 0;
        cpu_hold    = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = init_word(8'(i));
        model_reset();
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 38'h0);
        repeat (3) begin
            to_negedge();
            advance();
        end
        reset_n = 1'b1;
        idle_tick();

        // CPU write completes in its request cycle; the read returns it two cycles later.
        applyStimulus(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_wr_wait", 32'(avs_waitrequest), 32'h0);
        checkOutput("lit_wr_wren", 32'(ram_wren), 32'h1);
        advance();
        applyStimulus(1'b1, 1'b0, 8'h05, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_rd_wait1", 32'(avs_waitrequest), 32'h1);
        advance();
        to_negedge();
        checkOutput("lit_rd_wait2", 32'(avs_waitrequest), 32'h0);
        checkOutput("lit_rd_data", avs_readdata, 32'hDEADBEEF);
        advance();

        // JTAG read of 0x10 lands in MonDReg and leaves the address at 0x11.
        applyStimulus(1'b0, 1'b1, 8'h10, 32'h12345678, 4'hF, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1, 1'b0));
        to_negedge();
        advance();
        idle_tick();
        idle_tick();
        to_negedge();
        checkOutput("lit_mondreg_10", MonDReg, 32'h12345678);
        checkOutput("lit_busy_done", 32'(jtag_busy), 32'h0);
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 38'h0);
        to_negedge();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_addr_11", 32'(ram_address), 32'h11);
        advance();
        idle_tick();
        idle_tick();

        // JTAG write at 0xFF, then the address wraps to 0x00.
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b0, 1'b0));
        to_negedge();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, jdo_b(32'hA5A5A5A5));
        to_negedge();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_jwr_wren", 32'(ram_wren), 32'h1);
        checkOutput("lit_jwr_addr", 32'(ram_address), 32'hFF);
        checkOutput("lit_jwr_data", ram_wdata, 32'hA5A5A5A5);
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 38'h0);
        to_negedge();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_wrap_addr", 32'(ram_address), 32'h00);
        advance();
        idle_tick();
        idle_tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b1, 1'b0));
        to_negedge();
        advance();
        idle_tick();
        idle_tick();
        to_negedge();
        checkOutput("lit_mondreg_ff", MonDReg, 32'hA5A5A5A5);
        advance();

        // Held CPU read against JTAG reads: JTAG wins the first tie after reset, then grants alternate.
        pulse_reset();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 38'h0);
        to_negedge();
        advance();
        applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_rr_j0_addr", 32'(ram_address), 32'h00);
        checkOutput("lit_rr_j0_wait", 32'(avs_waitrequest), 32'h1);
        advance();
        to_negedge();
        checkOutput("lit_rr_jrd_wait", 32'(avs_waitrequest), 32'h1);
        advance();
        applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_rr_c0_addr", 32'(ram_address), 32'h20);
        advance();
        applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_rr_c0_done", 32'(avs_waitrequest), 32'h0);
        advance();
        to_negedge();
        checkOutput("lit_rr_j1_addr", 32'(ram_address), 32'h01);
        checkOutput("lit_rr_j1_busy", 32'(jtag_busy), 32'h1);
        advance();
        to_negedge();
        advance();
        to_negedge();
        checkOutput("lit_rr_c1_addr", 32'(ram_address), 32'h20);
        advance();
        to_negedge();
        advance();
        idle_tick();

        // A second post while one is pending is dropped and flagged; ocimem_a with bit 36 clears it.
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 38'h0);
        to_negedge();
        advance();
        to_negedge();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_ovr_set", 32'(jtag_overrun), 32'h1);
        advance();
        to_negedge();
        checkOutput("lit_ovr_single", 32'(jtag_busy), 32'h0);
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, jdo_a(8'h40, 1'b0, 1'b1));
        to_negedge();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_ovr_clr", 32'(jtag_overrun), 32'h0);
        advance();

`ifdef OCIMEM_CPU_WR_PROTECT_EN
        // Upper-half CPU writes are swallowed; JTAG writes there still land.
        applyStimulus(1'b0, 1'b1, 8'h80, 32'h11112222, 4'hF, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_prot_wren", 32'(ram_wren), 32'h0);
        checkOutput("lit_prot_viol", 32'(cpu_wr_violation), 32'h1);
        checkOutput("lit_prot_wait", 32'(avs_waitrequest), 32'h0);
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, jdo_a(8'h80, 1'b0, 1'b0));
        to_negedge();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, jdo_b(32'h33334444));
        to_negedge();
        advance();
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 38'h0);
        to_negedge();
        checkOutput("lit_prot_jwr", 32'(ram_wren), 32'h1);
        checkOutput("lit_prot_jaddr", 32'(ram_address), 32'h80);
        advance();
`endif

        // Random traffic with two asynchronous mid-operation resets.
        h_rd = 1'b0; h_wr = 1'b0; h_addr = 8'h00; h_wd = 32'h0; h_be = 4'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!cpu_hold) begin
                r      = $urandom_range(0, 9);
                h_rd   = (r < 4);
                h_wr   = (r >= 4 && r < 7);
                h_addr = 8'($urandom);
                h_wd   = $urandom;
                h_be   = 4'($urandom);
            end
            lo    = $urandom;
            hi    = $urandom;
            r_jdo = {hi[5:0], lo};
            r     = $urandom_range(0, 9);
            r_ta  = (r == 0);
            r_tna = (r == 1);
            r_tb  = (r == 2);
            if (r_ta) r_jdo[36] = ($urandom_range(0, 7) == 0);
            applyStimulus(h_rd, h_wr, h_addr, h_wd, h_be, r_ta, r_tna, r_tb, r_jdo);
            if (cyc == 1200 || cyc == 2400) begin
                #2 reset_n = 1'b0;
                to_negedge();
                advance();
                applyStimulus(1'b0, 1'b1, h_addr, h_wd, 4'hF, 1'b0, 1'b0, 1'b1, r_jdo);
                to_negedge();
                advance();
                reset_n = 1'b1;
            end else begin
                to_negedge();
                advance();
            end
        end
        repeat (4) idle_tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
